// File: rtl/tm1638_scheduler.sv
// Schedules key-scan and display-refresh command frames over the tm1638 byte engine and owns STB.
// Optional KEY_DEBOUNCE_EN: publish keys only when two consecutive scans return identical bytes.
module tm1638_scheduler #(
    parameter int unsigned SCAN_PERIOD = 100000,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_we,
    input  logic [3:0]  ram_addr,
    input  logic [7:0]  ram_wdata,
    input  logic [2:0]  brightness,
    input  logic        disp_on,
    output logic        tm_latch,
    output logic [7:0]  tm_out,
    output logic        tm_rw,
    input  logic [7:0]  tm_in,
    input  logic        busy,
    output logic        tm_cs,
    output logic [31:0] keys,
    output logic        keys_valid,
    output logic        frame_busy
);

    localparam int unsigned TMR_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [7:0] CMD_WRITE = 8'h40;
    localparam logic [7:0] CMD_READ  = 8'h42;
    localparam logic [7:0] CMD_ADDR  = 8'hC0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEY_CMD,
        S_KEY_RD,
        S_KEY_END,
        S_WR_CMD,
        S_GAP,
        S_ADDR,
        S_DATA,
        S_DATA_END,
        S_CTRL,
        S_CTRL_END
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } phase_t;

    state_t             r_state;
    state_t             r_gap_nxt;
    phase_t             r_ph;
    logic [3:0]         r_idx;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_scan_pend;
    logic               r_dirty;
    logic [7:0]         r_ram  [16];
    logic [7:0]         r_snap [16];
    logic [3:0]         r_ctrl_q;
    logic               r_ctrl_vld;
    logic [31:0]        r_shadow;
    logic [31:0]        r_keys;
    logic               r_keys_valid;
    logic               r_tm_latch;
    logic [7:0]         r_tm_out;
    logic               r_tm_rw;
    logic               r_tm_cs;
    logic               r_frame_busy;
`ifdef KEY_DEBOUNCE_EN
    logic [31:0]        r_prev_shadow;
`endif

    logic               w_wrap;
    logic               w_idle;
    logic               w_grant_key;
    logic               w_grant_ref;
    logic               w_ctrl_chg;
    logic               w_byte_st;
    logic               w_byte_done;
    logic [7:0]         w_byte_val;

    assign w_wrap      = (r_tmr == TMR_W'(SCAN_PERIOD - 1));
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_key = w_idle && r_scan_pend;
    assign w_grant_ref = w_idle && !r_scan_pend && r_dirty;
    // The first post-reset cycle has no valid history, so it cannot count as a change.
    assign w_ctrl_chg  = r_ctrl_vld && ({disp_on, brightness} != r_ctrl_q);
    assign w_byte_done = w_byte_st && (r_ph == PH_WAIT_LO) && !busy;

    // Byte to send in the current transfer state.
    always_comb begin
        w_byte_val = 8'h00;
        w_byte_st  = 1'b1;
        case (r_state)
            S_KEY_CMD: w_byte_val = CMD_READ;
            S_KEY_RD:  w_byte_val = 8'h00;
            S_WR_CMD:  w_byte_val = CMD_WRITE;
            S_ADDR:    w_byte_val = CMD_ADDR;
            S_DATA:    w_byte_val = r_snap[r_idx];
            S_CTRL:    w_byte_val = {4'h8, disp_on, brightness};
            default:   w_byte_st  = 1'b0;
        endcase
    end

    // Free-running scan timer, request flags and display RAM with frame snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr       <= '0;
            r_scan_pend <= 1'b0;
            r_dirty     <= 1'b1;
            r_ctrl_q    <= '0;
            r_ctrl_vld  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_ram[i]  <= 8'h00;
                r_snap[i] <= 8'h00;
            end
        end else begin
            r_tmr <= w_wrap ? '0 : r_tmr + TMR_W'(1);
            if (w_wrap)
                r_scan_pend <= 1'b1;
            else if (w_grant_key)
                r_scan_pend <= 1'b0;
            if (ram_we || w_ctrl_chg)
                r_dirty <= 1'b1;
            else if (w_grant_ref)
                r_dirty <= 1'b0;
            if (ram_we)
                r_ram[ram_addr] <= ram_wdata;
            if (w_grant_ref) begin
                for (int i = 0; i < 16; i++)
                    r_snap[i] <= r_ram[i];
            end
            r_ctrl_q   <= {disp_on, brightness};
            r_ctrl_vld <= 1'b1;
        end
    end

    // Frame sequencer with the per-byte latch/busy handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_gap_nxt    <= S_IDLE;
            r_ph         <= PH_ISSUE;
            r_idx        <= '0;
            r_gap_cnt    <= '0;
            r_shadow     <= '0;
            r_keys       <= '0;
            r_keys_valid <= 1'b0;
            r_tm_latch   <= 1'b0;
            r_tm_out     <= 8'h00;
            r_tm_rw      <= 1'b1;
            r_tm_cs      <= 1'b1;
            r_frame_busy <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
            r_prev_shadow <= '0;
`endif
        end else begin
            r_tm_latch   <= 1'b0;
            r_keys_valid <= 1'b0;

            if (w_byte_st) begin
                case (r_ph)
                    PH_ISSUE: begin
                        if (!busy) begin
                            r_tm_latch <= 1'b1;
                            r_tm_out   <= w_byte_val;
                            r_tm_rw    <= (r_state != S_KEY_RD);
                            r_ph       <= PH_WAIT_HI;
                        end
                    end
                    PH_WAIT_HI: if (busy)  r_ph <= PH_WAIT_LO;
                    PH_WAIT_LO: if (!busy) r_ph <= PH_ISSUE;
                    default:               r_ph <= PH_ISSUE;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    r_ph  <= PH_ISSUE;
                    r_idx <= '0;
                    if (w_grant_key) begin
                        r_tm_cs      <= 1'b0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_KEY_CMD;
                    end else if (w_grant_ref) begin
                        r_tm_cs      <= 1'b0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_WR_CMD;
                    end
                end
                S_KEY_CMD: begin
                    if (w_byte_done) begin
                        r_idx   <= '0;
                        r_state <= S_KEY_RD;
                    end
                end
                S_KEY_RD: begin
                    if (w_byte_done) begin
                        r_shadow[{r_idx[1:0], 3'b000} +: 8] <= tm_in;
                        if (r_idx[1:0] == 2'd3)
                            r_state <= S_KEY_END;
                        else
                            r_idx <= r_idx + 4'd1;
                    end
                end
                S_KEY_END: begin
                    r_tm_cs   <= 1'b1;
                    r_tm_rw   <= 1'b1;
                    r_gap_cnt <= '0;
                    r_gap_nxt <= S_IDLE;
                    r_state   <= S_GAP;
`ifdef KEY_DEBOUNCE_EN
                    r_prev_shadow <= r_shadow;
                    if (r_shadow == r_prev_shadow) begin
                        r_keys       <= r_shadow;
                        r_keys_valid <= 1'b1;
                    end
`else
                    r_keys       <= r_shadow;
                    r_keys_valid <= 1'b1;
`endif
                end
                S_WR_CMD: begin
                    if (w_byte_done) begin
                        r_tm_cs   <= 1'b1;
                        r_gap_cnt <= '0;
                        r_gap_nxt <= S_ADDR;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        r_state <= r_gap_nxt;
                        if (r_gap_nxt == S_IDLE)
                            r_frame_busy <= 1'b0;
                        else
                            r_tm_cs <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_ADDR: begin
                    if (w_byte_done) begin
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_byte_done) begin
                        if (r_idx == 4'd15)
                            r_state <= S_DATA_END;
                        else
                            r_idx <= r_idx + 4'd1;
                    end
                end
                S_DATA_END: begin
                    r_tm_cs   <= 1'b1;
                    r_gap_cnt <= '0;
                    r_gap_nxt <= S_CTRL;
                    r_state   <= S_GAP;
                end
                S_CTRL: begin
                    if (w_byte_done)
                        r_state <= S_CTRL_END;
                end
                S_CTRL_END: begin
                    r_tm_cs   <= 1'b1;
                    r_gap_cnt <= '0;
                    r_gap_nxt <= S_IDLE;
                    r_state   <= S_GAP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tm_latch   = r_tm_latch;
    assign tm_out     = r_tm_out;
    assign tm_rw      = r_tm_rw;
    assign tm_cs      = r_tm_cs;
    assign keys       = r_keys;
    assign keys_valid = r_keys_valid;
    assign frame_busy = r_frame_busy;

endmodule

// File: tb/tb_tm1638_scheduler.sv
// Directed bench for tm1638_scheduler with a byte-engine model (busy high 3 cycles per byte).
module tb_tm1638_scheduler;

    localparam int unsigned SP   = 200;
    localparam int unsigned GAP  = 4;
    localparam int          LOGN = 1024;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        ram_we     = 1'b0;
    logic [3:0]  ram_addr   = 4'h0;
    logic [7:0]  ram_wdata  = 8'h00;
    logic [2:0]  brightness = 3'd7;
    logic        disp_on    = 1'b1;
    logic        tm_latch;
    logic [7:0]  tm_out;
    logic        tm_rw;
    logic [7:0]  tm_in      = 8'h00;
    logic        busy       = 1'b0;
    logic        tm_cs;
    logic [31:0] keys;
    logic        keys_valid;
    logic        frame_busy;

    always #5 clk = ~clk;

    tm1638_scheduler #(.SCAN_PERIOD(SP), .CS_GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .brightness (brightness),
        .disp_on    (disp_on),
        .tm_latch   (tm_latch),
        .tm_out     (tm_out),
        .tm_rw      (tm_rw),
        .tm_in      (tm_in),
        .busy       (busy),
        .tm_cs      (tm_cs),
        .keys       (keys),
        .keys_valid (keys_valid),
        .frame_busy (frame_busy)
    );

    // Engine model and bus monitors
    logic [7:0] log_b  [LOGN];
    logic       log_rw [LOGN];
    logic [7:0] rd_bytes [4] = '{8'h04, 8'h00, 8'h40, 8'h00};
    int log_n = 0, bcnt = 0, rd_cnt = 0, kv_cnt = 0;
    int viol_busy = 0, viol_cs = 0;
    int hi_run = 0, min_hi = 100000, cs_falls = 0;
    logic cs_d = 1'b1, seen = 1'b0;

    always @(posedge clk) begin
        if (tm_latch) begin
            if (busy)  viol_busy <= viol_busy + 1;
            if (tm_cs) viol_cs   <= viol_cs + 1;
            if (log_n < LOGN) begin
                log_b[log_n]  <= tm_out;
                log_rw[log_n] <= tm_rw;
            end
            log_n <= log_n + 1;
            if (!tm_rw) begin
                tm_in  <= rd_bytes[rd_cnt[1:0]];
                rd_cnt <= rd_cnt + 1;
            end
            busy <= 1'b1;
            bcnt <= 3;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt <= 0;
            busy <= 1'b0;
        end
        if (keys_valid) kv_cnt <= kv_cnt + 1;
        if (tm_cs) begin
            hi_run <= hi_run + 1;
        end else begin
            hi_run <= 0;
            if (cs_d) begin
                cs_falls <= cs_falls + 1;
                if (seen && hi_run < min_hi) min_hi <= hi_run;
                seen <= 1'b1;
            end
        end
        cs_d <= tm_cs;
    end

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] getb(input int i);
        if (i < 0 || i >= log_n || i >= LOGN) return 8'hEE;
        return log_b[i];
    endfunction

    function automatic logic getrw(input int i);
        if (i < 0 || i >= log_n || i >= LOGN) return 1'b1;
        return log_rw[i];
    endfunction

    function automatic int find_b(input int from, input logic [7:0] v);
        for (int i = (from < 0 ? 0 : from); i < log_n && i < LOGN; i++)
            if (log_rw[i] && log_b[i] == v) return i;
        return -1;
    endfunction

    task automatic wait_log(input string tag, input int target, input int bound);
        int c;
        c = 0;
        while (log_n < target && c < bound) begin tick(1); c++; end
        chk(tag, 32'(log_n >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int c;
        c = 0;
        while (frame_busy && c < bound) begin tick(1); c++; end
        chk(tag, 32'(frame_busy), 32'd0);
    endtask

    task automatic wait_kv(input string tag, input int bound);
        int k0, c;
        k0 = kv_cnt;
        c  = 0;
        while (kv_cnt == k0 && c < bound) begin tick(1); c++; end
        chk(tag, 32'(kv_cnt != k0), 32'd1);
    endtask

    task automatic wait_scan(input string tag, input int bound);
        int t, c;
        t = rd_cnt + 4;
        c = 0;
        while (rd_cnt < t && c < bound) begin tick(1); c++; end
        chk(tag, 32'(rd_cnt >= t), 32'd1);
        tick(12);
    endtask

    task automatic ram_write(input logic [3:0] a, input logic [7:0] d);
        ram_addr  = a;
        ram_wdata = d;
        ram_we    = 1'b1;
        tick(1);
        ram_we    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},    32'(tm_cs),      32'd1);
        chk({tag, "_latch"}, 32'(tm_latch),   32'd0);
        chk({tag, "_rw"},    32'(tm_rw),      32'd1);
        chk({tag, "_out"},   32'(tm_out),     32'd0);
        chk({tag, "_keys"},  keys,            32'd0);
        chk({tag, "_kv"},    32'(keys_valid), 32'd0);
        chk({tag, "_fb"},    32'(frame_busy), 32'd0);
    endtask

    logic [31:0] exp_keys [3];
    int          exp_kv   [3];
    logic [7:0]  scan_k0  [3];

    initial begin
        int base, k, cnt, f1, f2, f3, fc, kv0;

        // Reset state
        #2 rst = 1'b0;
        tick(3);
        chk_reset_outputs("reset");

        // First frame after reset is a full refresh
        rst = 1'b1;
        wait_log("refresh0_bytes", 19, 400);
        wait_idle("refresh0_end", 200);
        chk("refresh0_wrcmd", 32'(getb(0)), 32'h40);
        chk("refresh0_addr",  32'(getb(1)), 32'hC0);
        cnt = 0;
        for (int i = 2; i < 18; i++) if (getb(i) != 8'h00) cnt++;
        chk("refresh0_data_nonzero", 32'(cnt), 32'd0);
        chk("refresh0_ctrl", 32'(getb(18)), 32'h8F);
        cnt = 0;
        for (int i = 0; i < 19; i++) if (!getrw(i)) cnt++;
        chk("refresh0_reads", 32'(cnt), 32'd0);
        chk("refresh0_len", 32'(log_n), 32'd19);
        chk("refresh0_cs_lows", 32'(cs_falls), 32'd3);
        chk("refresh0_gap", 32'(min_hi >= int'(GAP)), 32'd1);

        // Key scan: 0x42 then four reads, keys assembled K0 in low byte
        wait_kv("scan_kv", 1000);
        kv0 = kv_cnt;
        tick(3);
        chk("scan_keys", keys, 32'h0040_0004);
        chk("scan_kv_once", 32'(kv_cnt), 32'(kv0));
        k = find_b(19, 8'h42);
        chk("scan_cmd_pos", 32'(k), 32'd19);
        cnt = 0;
        for (int i = 1; i <= 4; i++) if (!getrw(k + i)) cnt++;
        chk("scan_reads", 32'(cnt), 32'd4);

        // RAM write during DATA byte 2 goes to the next refresh only
        base = log_n;
        ram_write(4'd5, 8'h11);
        wait_log("midwr_d2", base + 5, 400);
        ram_write(4'd5, 8'h6D);
        tick(600);
        f1 = find_b(base, 8'h40);
        chk("midwr_f1_addr", 32'(getb(f1 + 1)), 32'hC0);
        chk("midwr_f1_d5",   32'(getb(f1 + 7)), 32'h11);
        f2 = find_b(f1 + 1, 8'h40);
        chk("midwr_f2_found", 32'(f2 > f1), 32'd1);
        chk("midwr_f2_d5",   32'(getb(f2 + 7)), 32'h6D);
        f3 = find_b(f2 + 1, 8'h40);
        chk("midwr_no_third", 32'(f3), 32'hFFFF_FFFF);

        // Scan wraps while a refresh runs and RAM is dirtied again: key frame wins
        wait_kv("prio_sync", 1000);
        tick(110);
        base = log_n;
        ram_write(4'd1, 8'h22);
        wait_log("prio_started", base + 4, 400);
        ram_write(4'd1, 8'h23);
        tick(400);
        f1 = find_b(base, 8'h40);
        chk("prio_a_d1", 32'(getb(f1 + 3)), 32'h22);
        fc = find_b(f1, 8'h8F);
        chk("prio_key_first", 32'(getb(fc + 1)), 32'h42);
        f2 = find_b(fc, 8'h40);
        chk("prio_refresh_next", 32'(f2 > fc + 1), 32'd1);
        chk("prio_b_d1", 32'(getb(f2 + 3)), 32'h23);

        // Reset mid-DATA, then refresh restarts with cleared RAM
        wait_kv("rstmid_sync", 1000);
        tick(5);
        base = log_n;
        ram_write(4'd2, 8'h55);
        wait_log("rstmid_data", base + 8, 400);
        tick(1);
        chk("rstmid_fb_before", 32'(frame_busy), 32'd1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rstmid");
        tick(3);
        rst = 1'b1;
        base = log_n;
        wait_log("rstmid_refresh", base + 19, 400);
        chk("rstmid_wrcmd", 32'(getb(base)),      32'h40);
        chk("rstmid_addr",  32'(getb(base + 1)),  32'hC0);
        chk("rstmid_d2",    32'(getb(base + 4)),  32'h00);
        chk("rstmid_d5",    32'(getb(base + 7)),  32'h00);
        chk("rstmid_ctrl",  32'(getb(base + 18)), 32'h8F);
        wait_idle("rstmid_end", 200);

        // Key publication across three scans: K0 = 01, 02, 02
        scan_k0[0] = 8'h01; scan_k0[1] = 8'h02; scan_k0[2] = 8'h02;
`ifdef KEY_DEBOUNCE_EN
        exp_keys[0] = 32'h0; exp_keys[1] = 32'h0; exp_keys[2] = 32'h2;
        exp_kv[0] = 0; exp_kv[1] = 0; exp_kv[2] = 1;
`else
        exp_keys[0] = 32'h1; exp_keys[1] = 32'h2; exp_keys[2] = 32'h2;
        exp_kv[0] = 1; exp_kv[1] = 1; exp_kv[2] = 1;
`endif
        rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
        for (int s = 0; s < 3; s++) begin
            rd_bytes[0] = scan_k0[s];
            kv0 = kv_cnt;
            wait_scan($sformatf("deb_scan%0d", s), 600);
            chk($sformatf("deb_keys%0d", s), keys, exp_keys[s]);
            chk($sformatf("deb_kv%0d", s), 32'(kv_cnt - kv0), 32'(exp_kv[s]));
        end

        // Bus-level invariants over the whole run
        chk("latch_while_busy", 32'(viol_busy), 32'd0);
        chk("latch_with_cs_high", 32'(viol_cs), 32'd0);
        chk("min_cs_gap", 32'(min_hi >= int'(GAP)), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_scheduler.md
Name: tm1638_scheduler

Overview:
Transaction scheduler for the tm1638 byte engine (data_latch/busy/rw/data interface). It shares the single serial link between two requesters: a periodic key scan, and a display refresh driven by a 16-byte display RAM that user logic writes. It owns tm_cs, sequences every TM1638 command frame and publishes debounced key bytes. It replaces hand-written instruction_step sequencing in the top level.

Parameters:
SCAN_PERIOD, 100000, clk cycles between key-scan requests (min 64)
CS_GAP, 4, clk cycles tm_cs held high between frames (min 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ram_we  in  1  display RAM write strobe
ram_addr  in  4  display RAM byte address (TM1638 grid addr 0x0-0xF)
ram_wdata  in  8  display RAM write data
brightness  in  3  pulse-width code for display control command
disp_on  in  1  display enable bit of control command
tm_latch  out  1  start byte transfer on engine
tm_out  out  8  byte to engine
tm_rw  out  1  1 = write to module, 0 = read from module
tm_in  in  8  byte returned by engine on read
busy  in  1  engine busy
tm_cs  out  1  TM1638 STB, active-low
keys  out  32  key bytes K0..K3, K0 in [7:0]
keys_valid  out  1  one-cycle pulse when keys updated
frame_busy  out  1  high while tm_cs low or in CS gap

Behaviour:
- Reset (rst=0, async): tm_cs=1, tm_latch=0, tm_rw=1, tm_out=0, keys=0, keys_valid=0, frame_busy=0; RAM cleared to 0x00; dirty=1 (first frame is a full refresh); scan timer=0; state IDLE.
- Byte handshake: scheduler drives tm_out/tm_rw and raises tm_latch for exactly one clk; on the engine's busy high it waits until busy falls; next byte is issued no earlier than the clk after busy falls. tm_latch is never asserted while busy=1.
- Scan timer: counts 0..SCAN_PERIOD-1 and wraps, setting scan_pend on wrap; the timer never stalls.
- Arbitration in IDLE: scan_pend has priority over dirty; grant clears the respective flag at frame start.
- RAM writes are accepted on any cycle and set dirty; a write during a refresh sets dirty again, so exactly one further refresh follows.
- brightness/disp_on changes set dirty.
- States:
  - IDLE
  - KEY_CMD: cs low, write 0x42.
  - KEY_RD x4: rw=0, latch, capture tm_in into shadow byte n on busy fall.
  - KEY_END: cs high, update keys, pulse keys_valid.
  - WR_CMD: write 0x40, cs high.
  - GAP
  - ADDR: cs low, write 0xC0.
  - DATA x16: RAM[0..15] in order, snapshot at frame start.
  - DATA_END: cs high.
  - GAP
  - CTRL: cs low, write {5'b10001 with bit3=disp_on, brightness}, i.e. 8'h80|disp_on<<3|brightness.
  - CTRL_END: cs high.
  - GAP
  - IDLE.
- Every cs high is followed by GAP of CS_GAP cycles before the next cs low or IDLE.
- frame_busy is high from the first cs low until GAP exit.
- busy stuck high: no timeout; the scheduler waits indefinitely (engine is trusted).

Optional Feature:
KEY_DEBOUNCE_EN
- Defined: keys are updated and keys_valid pulses only when a scan's four bytes equal the previous scan's shadow (two consecutive identical scans); otherwise the shadow is stored and keys are held.
- Undefined: keys update and keys_valid pulses after every scan.

Test Plan:
- Reset release, engine model with busy 3 cycles -> first frame is a refresh: bytes 0x40, 0xC0, 16x 0x00, then 0x88|brightness with disp_on=1, brightness=7 -> 0x8F; tm_cs has 3 low periods; GAP>=CS_GAP.
- SCAN_PERIOD=200, model returns 0x04,0x00,0x40,0x00 -> after scan, keys=32'h0040_0004 and exactly one keys_valid pulse; 0x42 sent with tm_rw=0 on the 4 reads.
- ram_we addr 5 data 0x6D during DATA byte 2 -> current frame sends the old byte 5; a second refresh follows and sends 0x6D at position 5.
- scan_pend and dirty set in the same cycle -> key frame first, refresh next.
- Assert rst=0 mid-DATA -> all outputs reach reset values immediately; after release, a full refresh restarts from 0x40.
- KEY_DEBOUNCE_EN: scans return 0x01, 0x02, 0x02 in K0 -> keys_valid only after the third scan, keys[7:0]=0x02.
